// File: rtl/packed_mac_array.sv
// Packed int8/int4 multiply-accumulate array with run-level
// saturating accumulation and a three-stage pipeline.
module packed_mac_array #(
  parameter int LANES = 4,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     mode,
  input  logic [LANES*16-1:0]      x,
  input  logic [7:0]               y,
  output logic                     out_valid,
  output logic                     out_mode,
  output logic [LANES*4*ACC_W-1:0] acc,
  output logic [LANES-1:0]         ovf,
  output logic [15:0]              run_len,
  output logic                     busy
);

  localparam int SLOTS = LANES * 4;
  localparam logic IDLE  = 1'b0;
  localparam logic ACCUM = 1'b1;

  logic                     state;
  logic                     run_mode;
  logic                     s1_valid, s1_last, s1_first, s1_mode;
  logic [LANES*16-1:0]      s1_x;
  logic [7:0]               s1_y;
  logic [SLOTS*ACC_W-1:0]   prod;
  logic                     s2_valid, s2_last, s2_first, s2_mode;
  logic [SLOTS*ACC_W-1:0]   s2_prod;
  logic [SLOTS*ACC_W-1:0]   accum, sum;
  logic [SLOTS-1:0]         clip;
  logic [LANES-1:0]         ovf_run, ovf_next;
  logic [15:0]              cnt, cnt_next;

  function automatic logic [ACC_W-1:0] mul8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic signed [ACC_W-1:0] ea, eb;
    ea = {{(ACC_W-8){a[7]}}, a};
    eb = {{(ACC_W-8){b[7]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [ACC_W-1:0] mul4(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic signed [ACC_W-1:0] ea, eb;
    ea = {{(ACC_W-4){a[3]}}, a};
    eb = {{(ACC_W-4){b[3]}}, b};
    return ea * eb;
  endfunction

  // MSB of the result flags a clamp; the rest is the clamped sum.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0] w;
    w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (w[ACC_W] != w[ACC_W-1])
      return {1'b1, w[ACC_W], {(ACC_W-1){~w[ACC_W]}}};
    return {1'b0, w[ACC_W-1:0]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      run_mode <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_mode  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x     <= x;
        s1_y     <= y;
        s1_last  <= in_last;
        s1_first <= (state == IDLE);
        s1_mode  <= (state == IDLE) ? mode : run_mode;
        if (state == IDLE)
          run_mode <= mode;
        state <= in_last ? IDLE : ACCUM;
      end
    end
  end

  always_comb begin
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < 4; s++) begin
        if (s1_mode)
          prod[(4*l+s)*ACC_W +: ACC_W] =
            mul4(s1_x[16*l+4*s +: 4], s1_y[3:0]);
        else if (s < 2)
          prod[(4*l+s)*ACC_W +: ACC_W] =
            mul8(s1_x[16*l+8*s +: 8], s1_y);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_mode  <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last  <= s1_last;
        s2_first <= s1_first;
        s2_mode  <= s1_mode;
        s2_prod  <= prod;
      end
    end
  end

  always_comb begin
    logic [ACC_W:0] r;
    r    = '0;
    sum  = '0;
    clip = '0;
    for (int i = 0; i < SLOTS; i++) begin
      r = sat_add(s2_first ? {ACC_W{1'b0}}
                           : accum[i*ACC_W +: ACC_W],
                  s2_prod[i*ACC_W +: ACC_W]);
      sum[i*ACC_W +: ACC_W] = r[ACC_W-1:0];
      clip[i] = r[ACC_W];
    end
  end

  always_comb begin
    ovf_next = '0;
    for (int l = 0; l < LANES; l++)
      ovf_next[l] = (!s2_first & ovf_run[l])
                  | (|clip[4*l +: 4]);
  end

  assign cnt_next = s2_first ? 16'd1
                  : cnt + {15'd0, cnt != 16'hFFFF};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accum     <= '0;
      ovf_run   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      acc       <= '0;
      ovf       <= '0;
      run_len   <= '0;
    end else begin
      out_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        accum   <= sum;
        ovf_run <= ovf_next;
        cnt     <= cnt_next;
        if (s2_last) begin
          acc      <= sum;
          ovf      <= ovf_next;
          run_len  <= cnt_next;
          out_mode <= s2_mode;
        end
      end
    end
  end

  assign busy = (state == ACCUM) | s1_valid | s2_valid;

endmodule

// File: tb/tb_packed_mac_array.sv
// Bench for packed_mac_array: directed and random runs against an
// arithmetic run model, at ACC_W=24 and ACC_W=16 side by side.
module tb_packed_mac_array;
  localparam int LANES = 4;
  localparam int WA = 24;
  localparam int WB = 16;

  logic clk = 0, reset = 1;
  logic in_valid = 0, in_last = 0, mode = 0;
  logic [63:0] x = '0;
  logic [7:0] y = '0;

  logic ov_a, om_a, busy_a, ov_b, om_b, busy_b;
  logic [LANES*4*WA-1:0] acc_a;
  logic [LANES*4*WB-1:0] acc_b;
  logic [3:0] ovf_a, ovf_b;
  logic [15:0] rl_a, rl_b;

  packed_mac_array #(.LANES(LANES), .ACC_W(WA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_last(in_last), .mode(mode), .x(x), .y(y),
    .out_valid(ov_a), .out_mode(om_a), .acc(acc_a),
    .ovf(ovf_a), .run_len(rl_a), .busy(busy_a));

  packed_mac_array #(.LANES(LANES), .ACC_W(WB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_last(in_last), .mode(mode), .x(x), .y(y),
    .out_valid(ov_b), .out_mode(om_b), .acc(acc_b),
    .ovf(ovf_b), .run_len(rl_b), .busy(busy_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  typedef struct {
    int          cyc;
    logic        m;
    logic [383:0] a;
    logic [255:0] b;
    logic [3:0]  oa, ob;
    logic [15:0] rl;
  } res_t;
  res_t q[$];

  longint sa[LANES][4];
  longint sb[LANES][4];
  logic [3:0] fa, fb;
  int len;
  bit open = 0;
  logic rmode;

  task automatic chk(string tag, logic [383:0] obs,
                     logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint prodm(logic m, logic [15:0] lx,
                                   logic [7:0] ly, int s);
    int a, b;
    if (!m) begin
      if (s > 1) return 0;
      a = int'(lx[8*s +: 8]);
      b = int'(ly);
      if (a > 127) a -= 256;
      if (b > 127) b -= 256;
    end else begin
      a = int'(lx[4*s +: 4]);
      b = int'(ly[3:0]);
      if (a > 7) a -= 16;
      if (b > 7) b -= 16;
    end
    return longint'(a * b);
  endfunction

  function automatic longint clampw(longint v, int w,
                                    output bit hit);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    hit = 0;
    if (v > hi) begin hit = 1; return hi; end
    if (v < lo) begin hit = 1; return lo; end
    return v;
  endfunction

  task automatic beat(logic [63:0] bx, logic [7:0] by,
                      logic bm, logic bl);
    bit first, h;
    longint p;
    logic [63:0] t;
    res_t r;
    in_valid = 1; x = bx; y = by; mode = bm; in_last = bl;
    first = !open;
    if (first) begin
      rmode = bm; len = 0; fa = '0; fb = '0;
    end
    if (len < 65535) len++;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < 4; s++) begin
        p = prodm(rmode, bx[16*l +: 16], by, s);
        sa[l][s] = clampw((first ? 0 : sa[l][s]) + p, WA, h);
        if (h) fa[l] = 1'b1;
        sb[l][s] = clampw((first ? 0 : sb[l][s]) + p, WB, h);
        if (h) fb[l] = 1'b1;
      end
    if (bl) begin
      r.cyc = cyc + 3; r.m = rmode; r.oa = fa; r.ob = fb;
      r.rl = 16'(len); r.a = '0; r.b = '0;
      for (int l = 0; l < LANES; l++)
        for (int s = 0; s < 4; s++) begin
          t = sa[l][s]; r.a[(4*l+s)*WA +: WA] = t[WA-1:0];
          t = sb[l][s]; r.b[(4*l+s)*WB +: WB] = t[WB-1:0];
        end
      q.push_back(r);
      open = 0;
    end else begin
      open = 1;
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic bubble(int n);
    repeat (n) begin
      in_valid = 0;
      in_last = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      @(negedge clk);
    end
    in_last = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_acc_a"}, acc_a, 0);
    chk({tag, "_acc_b"}, acc_b, 0);
    chk({tag, "_ovf"}, {ovf_a, ovf_b}, 0);
    chk({tag, "_run_len"}, {rl_a, rl_b}, 0);
    chk({tag, "_flags"}, {ov_a, om_a, busy_a, ov_b, om_b, busy_b}, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit due;
      res_t r;
      due = (q.size() > 0) && (q[0].cyc == cyc);
      chk("out_valid_a", ov_a, due);
      chk("out_valid_b", ov_b, due);
      if (due) begin
        r = q.pop_front();
        chk("out_mode_a", om_a, r.m);
        chk("out_mode_b", om_b, r.m);
        chk("acc_a", acc_a, r.a);
        chk("acc_b", acc_b, r.b);
        chk("ovf_a", ovf_a, r.oa);
        chk("ovf_b", ovf_b, r.ob);
        chk("run_len_a", rl_a, r.rl);
        chk("run_len_b", rl_b, r.rl);
      end
    end
  end

  initial begin
    logic [63:0] rx;
    int n;
    #2 reset = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1;
    @(negedge clk);
    mon_en = 1;

    // single-beat int8 run
    beat(64'h807F, 8'h80, 0, 1);
    chk("busy_open", busy_a, 1);
    bubble(2);
    chk("t1_slot0", acc_a[23:0], 24'hFFC080);
    chk("t1_slot1", acc_a[47:24], 24'h004000);
    chk("t1_busy_done", {busy_a, busy_b}, 0);

    // single-beat int4 run
    beat(64'h8F71, 8'h09, 1, 1);
    bubble(2);
    chk("t2_slots", acc_a[95:0],
        {24'h000038, 24'h000007, 24'hFFFFCF, 24'hFFFFF9});
    chk("t2_mode", om_a, 1);

    // four beats with bubbles in the middle
    beat(64'h0202, 8'd3, 0, 0);
    beat(64'h0202, 8'd3, 0, 0);
    bubble(2);
    beat(64'h0202, 8'd3, 0, 0);
    beat(64'h0202, 8'd3, 0, 1);
    bubble(2);
    chk("t3_slots", acc_a[47:0], {24'd24, 24'd24});
    chk("t3_run_len", rl_a, 4);

    // saturation at 16 bits then a clean run back-to-back
    repeat (2) beat({4{16'h7F7F}}, 8'h7F, 0, 0);
    beat({4{16'h7F7F}}, 8'h7F, 0, 1);
    beat(64'h0101, 8'h01, 0, 1);
    bubble(4);

    // mode change mid-run is ignored; next run follows at once
    beat(64'h1234_F00F_8081_7F80, 8'hC3, 0, 0);
    beat(64'h0F0F_1111_A5A5_7777, 8'h95, 1, 1);
    beat(64'h8F71_1234_FFFF_8080, 8'h97, 1, 1);
    bubble(4);

    // reset in the middle of a five-beat run
    beat({$urandom, $urandom}, 8'h55, 0, 0);
    beat({$urandom, $urandom}, 8'hAA, 0, 0);
    in_valid = 1; x = {$urandom, $urandom}; y = 8'h33;
    reset = 0;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    in_valid = 0;
    reset = 1;
    open = 0;
    bubble(2);
    chk("post_reset_idle", {ov_a, busy_a}, 0);
    beat(64'hFF01_807F_0102_7F7F, 8'h81, 0, 1);
    bubble(3);

    // random runs, random bubbles, random ignored mode flips
    for (int r = 0; r < 60; r++) begin
      n = $urandom_range(1, 7);
      for (int b = 0; b < n; b++) begin
        rx = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rx = {4{16'h8080}};
        beat(rx, 8'($urandom), 1'($urandom_range(0, 1)),
             b == n - 1);
        if ($urandom_range(0, 4) == 0)
          bubble($urandom_range(1, 3));
      end
      if ($urandom_range(0, 2) == 0)
        bubble($urandom_range(1, 2));
    end
    bubble(6);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/packed_mac_array.md
# packed_mac_array

Parametrised packed multiply-accumulate array for the opu datapath. Each of LANES lanes multiplies a packed operand word by one shared 8-bit operand: two signed int8×int8 products per lane in mode 0, or four signed int4×int4 products per lane in mode 1. Products accumulate across a run of beats delimited by `in_last`, with signed saturation and a sticky overflow flag. It sits after the operand fetch stage and feeds the output quantiser. It also adds the run-level accumulation, saturation and handshake that a single-shot packed multiplier lacks.

## Interface
- LANES, 4, number of lanes; each lane has a 16-bit `x` slice.
- ACC_W, 24, signed accumulator width per product slot; legal range 16..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid; the block is always ready and has no backpressure.
- in_last  in  1  final beat of the run; qualified by `in_valid`.
- mode  in  1  0 = 2×int8, 1 = 4×int4; sampled only on the first beat of a run.
- x  in  LANES*16  lane l uses x[16l+15:16l]; mode 0 packs bytes [7:0] and [15:8]; mode 1 packs nibbles [3:0], [7:4], [11:8] and [15:12] as slots 0..3.
- y  in  8  shared operand; mode 0 uses y[7:0]; mode 1 uses y[3:0]; all values are signed.
- out_valid  out  1  one-cycle pulse marking a completed run result.
- out_mode  out  1  mode of the reported run.
- acc  out  LANES*4*ACC_W  slot s of lane l is at bits [(4l+s+1)*ACC_W-1 : (4l+s)*ACC_W]; in mode 0, slots 2 and 3 are 0.
- ovf  out  LANES  sticky saturation flag per lane for the reported run.
- run_len  out  16  number of beats in the reported run, saturating at 0xFFFF.
- busy  out  1  high while a run is open or still in the pipeline.

## Operation
- Pipeline:
  - S1 registers `x`, `y`, the valid, last and first flags, and the run mode.
  - S2 registers the sign-extended products.
  - S3 holds the accumulators.
- Run state machine, evaluated at S1 capture:
  - IDLE: on `in_valid`, capture `mode` as the run mode and mark the beat first. Go to ACCUM, or stay in IDLE if `in_last` is also high (a single-beat run).
  - ACCUM: on `in_valid`, mark the beat non-first with the held run mode; `mode` is ignored. `in_last` returns the machine to IDLE.
- Accumulate at S3:
  - A first beat loads its product into the accumulator and clears `ovf` and the beat counter.
  - A non-first beat adds its product into the accumulator.
  - Sums are computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp in lane l sets that lane's ovf bit for the rest of the run.
- On a last beat at S3, the final sums are written to `acc`, together with `ovf`, `run_len` and `out_mode`, and `out_valid` pulses. Outputs hold until the next result.
- In mode 0, products are 16 bits signed. In mode 1, products are 8 bits signed. Both are sign-extended to ACC_W.
- `in_valid` low cycles inside a run are bubbles: the accumulators hold and nothing advances.
- `in_last` without `in_valid` is ignored.

## Timing
- Latency: a last beat sampled at edge k produces `out_valid` high for exactly the cycle following edge k+2.
- Throughput is one beat per cycle. Back-to-back runs need no bubble: a last beat at edge k and the next run's first beat at edge k+1 are both legal.
- `busy` is high from the edge after a first beat until the edge that asserts `out_valid` for that run's last beat.
- Reset values: out_valid 0, out_mode 0, acc 0, ovf 0, run_len 0, busy 0, state IDLE, all pipeline valids 0.
- Reset asserted mid-run clears everything immediately and the open run is discarded. After reset is released, the first valid beat starts a new run.

## Test plan
- Mode 0, one-beat run: lane 0 x=0x807F, y=0x80, in_last=1 -> 3 cycles later out_valid=1; slot0=-16256, slot1=16384, slots 2 and 3 = 0, run_len=1, ovf=0.
- Mode 1, one-beat run: x=0x8F71, y=0x09 -> slots 0..3 = -7, -49, 7, 56; out_mode=1.
- Mode 0, 4-beat run with 2 bubble cycles between beats 2 and 3: x=0x0202, y=3 each beat -> slots 0 and 1 = 24, run_len=4, one out_valid pulse only.
- ACC_W=16, mode 0: three beats with x=0x7F7F, y=0x7F -> slots 0 and 1 = 32767, ovf=1. The next run (x=0x0101, y=1, one beat) gives 1 with ovf=0.
- mode toggled to 1 on beat 2 of a mode 0 run, followed immediately by a mode 1 run -> first result out_mode=0 with int8 sums; second result out_mode=1 one cycle after the first with no bubble.
- reset low for 1 cycle during beat 3 of a 5-beat run -> all outputs 0 at once, no out_valid, busy=0. A fresh 1-beat run afterwards gives correct values.
